// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
//
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and sticky overflow / underflow
// error flags. A push while full is accepted when a pop is accepted in
// the same cycle, so one push and one pop per cycle can be sustained even
// at full occupancy.
//
// Optional build macro:
//   FIFO_FWFT_EN  - first-word-fall-through reads. data_out shows the head
//                   word combinationally and data_valid = !empty. When the
//                   macro is undefined, reads have one cycle of registered
//                   latency and data_valid pulses once per accepted pop.
//
// Parameters:
//   WORD_SIZE          data width in bits (>= 1)
//   ADDRESS_SIZE       pointer width, DEPTH = 2**ADDRESS_SIZE (>= 1)
//   ALMOST_FULL_LEVEL  almost_full when count >= this (1..DEPTH)
//   ALMOST_EMPTY_LEVEL almost_empty when count <= this (0..DEPTH-1)
//
// Ports:
//   clock         in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   write_enable  in   push request
//   data_in       in   push data
//   read_enable   in   pop request
//   clear_errors  in   clears overflow / underflow (a same-cycle set wins)
//   data_out      out  read data
//   data_valid    out  data_out holds a popped word / the head word
//   full, empty   out  registered status
//   almost_full   out  registered threshold status
//   almost_empty  out  registered threshold status
//   count         out  stored entries, 0..DEPTH
//   overflow      out  sticky: push rejected
//   underflow     out  sticky: pop requested while empty
// ---------------------------------------------------------------------------
module fifo_param #(
  parameter int WORD_SIZE          = 8,
  parameter int ADDRESS_SIZE       = 4,
  parameter int ALMOST_FULL_LEVEL  = 14,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    write_enable,
  input  logic [WORD_SIZE-1:0]    data_in,
  input  logic                    read_enable,
  input  logic                    clear_errors,
  output logic [WORD_SIZE-1:0]    data_out,
  output logic                    data_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int DEPTH       = 1 << ADDRESS_SIZE;
  localparam int COUNT_WIDTH = ADDRESS_SIZE + 1;

  localparam logic [COUNT_WIDTH-1:0] DEPTH_COUNT        = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] ALMOST_FULL_COUNT  = COUNT_WIDTH'(ALMOST_FULL_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] ALMOST_EMPTY_COUNT = COUNT_WIDTH'(ALMOST_EMPTY_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] ONE_COUNT          = COUNT_WIDTH'(1);

  logic [WORD_SIZE-1:0]    memory [DEPTH];
  logic [ADDRESS_SIZE-1:0] write_pointer;
  logic [ADDRESS_SIZE-1:0] read_pointer;
  logic                    read_accept;
  logic                    write_accept;
  logic [COUNT_WIDTH-1:0]  count_next;

  // Accept logic. A pop is never accepted on an empty FIFO, so a
  // simultaneous read+write on empty takes only the write. A push on a
  // full FIFO is allowed exactly when the pop frees the slot this cycle.
  always_comb begin
    read_accept  = read_enable && !empty;
    write_accept = write_enable && (!full || read_accept);
    count_next   = count;
    if (write_accept && !read_accept) begin
      count_next = count + ONE_COUNT;
    end else if (!write_accept && read_accept) begin
      count_next = count - ONE_COUNT;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clock) begin
    if (write_accept) begin
      memory[write_pointer] <= data_in;
    end
  end

  // Pointers wrap naturally at DEPTH because they are ADDRESS_SIZE wide.
  // Status flags are registered from count_next so they line up with
  // the count they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      almost_full   <= 1'b0;
      almost_empty  <= 1'b1;
    end else begin
      if (write_accept) begin
        write_pointer <= write_pointer + 1'b1;
      end
      if (read_accept) begin
        read_pointer <= read_pointer + 1'b1;
      end
      count        <= count_next;
      full         <= (count_next == DEPTH_COUNT);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= ALMOST_FULL_COUNT);
      almost_empty <= (count_next <= ALMOST_EMPTY_COUNT);
    end
  end

  // Sticky error flags: a set condition in the same cycle as clear_errors
  // keeps the flag set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enable && !write_accept) begin
        overflow <= 1'b1;
      end else if (clear_errors) begin
        overflow <= 1'b0;
      end
      if (read_enable && empty) begin
        underflow <= 1'b1;
      end else if (clear_errors) begin
        underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible combinationally; forced to zero while empty so
  // the output matches its reset value and never exposes stale storage.
  assign data_out   = empty ? '0 : memory[read_pointer];
  assign data_valid = !empty;
`else
  // Registered read: data_out captures the head on an accepted pop and
  // holds it otherwise; data_valid is a one-cycle pulse per pop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= read_accept;
      if (read_accept) begin
        data_out <= memory[read_pointer];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
//
// Directed self-checking bench for fifo_param with default parameters
// (8-bit words, 16 entries, almost_full at 14, almost_empty at 2).
// Expected values are hand-derived; the FIFO_FWFT_EN macro selects the
// read-path expectations to match the build of the design.
// ---------------------------------------------------------------------------
module tb_fifo_param;

  logic       clock;
  logic       reset_n;
  logic       write_enable;
  logic [7:0] data_in;
  logic       read_enable;
  logic       clear_errors;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total_checks = 0;
  int bad_checks   = 0;

  fifo_param #(
    .WORD_SIZE          (8),
    .ADDRESS_SIZE       (4),
    .ALMOST_FULL_LEVEL  (14),
    .ALMOST_EMPTY_LEVEL (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .clear_errors (clear_errors),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, and return 1 ns after
  // it with the inputs idle again.
  task automatic applyStimulus(input logic we, input logic [7:0] din,
                               input logic re, input logic clr);
    write_enable = we;
    data_in      = din;
    read_enable  = re;
    clear_errors = clr;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
    data_in      = 8'h00;
    read_enable  = 1'b0;
    clear_errors = 1'b0;
  endtask

  // Pop one word (optionally with a simultaneous push) and check the word.
  task automatic popWord(input string tag, input logic [7:0] expected,
                         input logic do_push, input logic [7:0] push_data);
`ifdef FIFO_FWFT_EN
    checkOutput({tag, "_data"},  32'(data_out),   32'(expected));
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'(1));
    applyStimulus(do_push, push_data, 1'b1, 1'b0);
`else
    applyStimulus(do_push, push_data, 1'b1, 1'b0);
    checkOutput({tag, "_data"},  32'(data_out),   32'(expected));
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'(1));
`endif
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"},        32'(count),        32'(0));
    checkOutput({tag, "_empty"},        32'(empty),        32'(1));
    checkOutput({tag, "_almost_empty"}, 32'(almost_empty), 32'(1));
    checkOutput({tag, "_full"},         32'(full),         32'(0));
    checkOutput({tag, "_almost_full"},  32'(almost_full),  32'(0));
    checkOutput({tag, "_data_out"},     32'(data_out),     32'(0));
    checkOutput({tag, "_data_valid"},   32'(data_valid),   32'(0));
    checkOutput({tag, "_overflow"},     32'(overflow),     32'(0));
    checkOutput({tag, "_underflow"},    32'(underflow),    32'(0));
  endtask

  initial begin
    reset_n      = 1'b0;
    write_enable = 1'b0;
    data_in      = 8'h00;
    read_enable  = 1'b0;
    clear_errors = 1'b0;

    // Reset state, then release reset away from a clock edge.
    #12;
    checkResetState("reset");
    #10;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Fill with 0x01..0x10.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d_count", i), 32'(count), 32'(i));
      checkOutput($sformatf("fill%0d_almost_full", i), 32'(almost_full),
                  32'(i >= 14));
      checkOutput($sformatf("fill%0d_full", i), 32'(full), 32'(i == 16));
      checkOutput($sformatf("fill%0d_almost_empty", i), 32'(almost_empty),
                  32'(i <= 2));
      checkOutput($sformatf("fill%0d_empty", i), 32'(empty), 32'(0));
`ifdef FIFO_FWFT_EN
      if (i == 1) begin
        checkOutput("fwft_first_data",  32'(data_out),   32'(8'h01));
        checkOutput("fwft_first_valid", 32'(data_valid), 32'(1));
      end
`else
      checkOutput($sformatf("fill%0d_valid", i), 32'(data_valid), 32'(0));
`endif
    end

    // Push into a full FIFO without a pop: overflow, nothing stored.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf_flag",  32'(overflow), 32'(1));
    checkOutput("ovf_count", 32'(count),    32'(16));
    checkOutput("ovf_full",  32'(full),     32'(1));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(overflow), 32'(0));

    // Push+pop at full: head leaves, 0xBB enters, still full.
    popWord("pushpop", 8'h01, 1'b1, 8'hBB);
    checkOutput("pushpop_count",    32'(count),    32'(16));
    checkOutput("pushpop_full",     32'(full),     32'(1));
    checkOutput("pushpop_overflow", 32'(overflow), 32'(0));

    // Drain: 0x02..0x10 then 0xBB, exercising pointer wrap.
    for (int k = 0; k < 16; k++) begin
      popWord($sformatf("drain%0d", k), (k < 15) ? 8'(k + 2) : 8'hBB,
              1'b0, 8'h00);
      checkOutput($sformatf("drain%0d_count", k), 32'(count), 32'(15 - k));
      checkOutput($sformatf("drain%0d_almost_empty", k), 32'(almost_empty),
                  32'((15 - k) <= 2));
      checkOutput($sformatf("drain%0d_empty", k), 32'(empty), 32'(k == 15));
    end
    checkOutput("drain_underflow", 32'(underflow), 32'(0));

    // Idle cycle after the drain.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
    checkOutput("idle_valid", 32'(data_valid), 32'(0));
    checkOutput("idle_data",  32'(data_out),   32'(0));
`else
    checkOutput("idle_valid", 32'(data_valid), 32'(0));
    checkOutput("idle_hold",  32'(data_out),   32'(8'hBB));
`endif

    // Read+write on empty: write taken, read ignored, underflow raised.
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    checkOutput("rw_empty_count",     32'(count),     32'(1));
    checkOutput("rw_empty_underflow", 32'(underflow), 32'(1));
    checkOutput("rw_empty_empty",     32'(empty),     32'(0));
`ifdef FIFO_FWFT_EN
    checkOutput("rw_empty_valid", 32'(data_valid), 32'(1));
`else
    checkOutput("rw_empty_valid", 32'(data_valid), 32'(0));
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("underflow_cleared", 32'(underflow), 32'(0));
    popWord("pop55", 8'h55, 1'b0, 8'h00);
    checkOutput("pop55_empty", 32'(empty), 32'(1));

    // Clear and underflow in the same cycle: the set wins.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("set_wins_underflow", 32'(underflow), 32'(1));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    // Push 5 words, then assert reset mid-burst between edges.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    end
    checkOutput("burst_count", 32'(count), 32'(5));
    write_enable = 1'b1;
    data_in      = 8'h70;
    #2;
    reset_n = 1'b0;
    #1;
    checkResetState("midreset");
    write_enable = 1'b0;
    data_in      = 8'h00;
    #4;
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_reset_empty", 32'(empty), 32'(1));
    checkOutput("post_reset_count", 32'(count), 32'(0));

    // FIFO still works after reset.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    popWord("post_reset_pop", 8'h3C, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
